bcd_scoreboard: RTL

Multi-digit BCD score counter with an integrated 5x5 glyph renderer for the video path. It holds the game score as NDIGITS packed BCD nibbles and accepts increment, load and clear commands. It turns the beam position (hpos/vpos) into a registered pixel for a scaled digit row placed at a fixed screen origin. It replaces per-digit ROM instantiation in the playfield top level.

---
 rtl/bcd_scoreboard.sv | 127 ++++++++++++
 1 files changed

// File: rtl/bcd_scoreboard.sv
// bcd_scoreboard: packed BCD score counter with a two-stage pipelined 5x5 glyph renderer.
module bcd_scoreboard #(
  parameter int NDIGITS    = 4,
  parameter int SCALE_LOG2 = 2,
  parameter int X0         = 16,
  parameter int Y0         = 8,
  parameter int BLANK_LZ   = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [8:0]             hpos,
  input  logic [8:0]             vpos,
  input  logic                   inc,
  input  logic                   load,
  input  logic [4*NDIGITS-1:0]   load_value,
  input  logic                   clear,
  output logic [4*NDIGITS-1:0]   score,
  output logic                   overflow,
  output logic                   pixel
);
  localparam int S  = 1 << SCALE_LOG2;
  localparam int XW = NDIGITS * 6 * S;
  localparam int YH = 5 * S;

  function automatic logic [0:4][4:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = {5'h1F, 5'h11, 5'h11, 5'h11, 5'h1F};
      4'd1:    glyph = {5'h0C, 5'h04, 5'h04, 5'h04, 5'h1F};
      4'd2:    glyph = {5'h1F, 5'h01, 5'h1F, 5'h10, 5'h1F};
      4'd3:    glyph = {5'h1F, 5'h01, 5'h1F, 5'h01, 5'h1F};
      4'd4:    glyph = {5'h11, 5'h11, 5'h1F, 5'h01, 5'h01};
      4'd5:    glyph = {5'h1F, 5'h10, 5'h1F, 5'h01, 5'h1F};
      4'd6:    glyph = {5'h1F, 5'h10, 5'h1F, 5'h11, 5'h1F};
      4'd7:    glyph = {5'h1F, 5'h01, 5'h01, 5'h01, 5'h01};
      4'd8:    glyph = {5'h1F, 5'h11, 5'h1F, 5'h11, 5'h1F};
      4'd9:    glyph = {5'h1F, 5'h11, 5'h1F, 5'h01, 5'h1F};
      default: glyph = '0;
    endcase
  endfunction

  logic [NDIGITS-1:0][3:0] score_q, score_d, inc_v, clamp_v;
  logic                    ovf_q, ovf_d, carry;

  always_comb begin
    carry = 1'b1;
    for (int i = 0; i < NDIGITS; i++) begin
      inc_v[i]   = carry ? (score_q[i] == 4'd9 ? 4'd0 : score_q[i] + 4'd1) : score_q[i];
      carry      = carry & (score_q[i] == 4'd9);
      clamp_v[i] = load_value[4*i +: 4] > 4'd9 ? 4'd9 : load_value[4*i +: 4];
    end
    score_d = clear ? '0 : load ? clamp_v : inc ? inc_v : score_q;
    ovf_d   = (clear | load) ? 1'b0 : inc ? (ovf_q | carry) : ovf_q;
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      score_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      score_q <= score_d;
      ovf_q   <= ovf_d;
    end

  // Stage 1: beam position to glyph cell, digit slot and blanking flag.
  logic       in_d, blank_d, zero_run;
  logic [9:0] dx, dy, col;
  logic [3:0] slot, nib_d;
  logic [2:0] xbit_d, row_d;

  always_comb begin
    in_d     = int'(hpos) >= X0 && int'(hpos) < X0 + XW && int'(vpos) >= Y0 && int'(vpos) < Y0 + YH;
    dx       = {1'b0, hpos} - 10'(X0);
    dy       = {1'b0, vpos} - 10'(Y0);
    col      = dx >> SCALE_LOG2;
    slot     = 4'(col / 10'd6);
    xbit_d   = 3'(col % 10'd6);
    row_d    = in_d ? 3'(dy >> SCALE_LOG2) : 3'd0;
    nib_d    = 4'd0;
    blank_d  = 1'b0;
    zero_run = 1'b1;
    for (int i = NDIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run & (score_q[i] == 4'd0);
      if (int'(slot) == NDIGITS - 1 - i) begin
        nib_d   = score_q[i];
        blank_d = BLANK_LZ != 0 && i != 0 && zero_run;
      end
    end
  end

  logic       in_q, blank_q, pixel_q;
  logic [3:0] nib_q;
  logic [2:0] xbit_q, row_q;

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      in_q    <= 1'b0;
      blank_q <= 1'b0;
      nib_q   <= 4'd0;
      xbit_q  <= 3'd0;
      row_q   <= 3'd0;
    end else begin
      in_q    <= in_d;
      blank_q <= blank_d;
      nib_q   <= nib_d;
      xbit_q  <= xbit_d;
      row_q   <= row_d;
    end

  // Stage 2: glyph row lookup; column 5 of each cell is the inter-digit gap.
  logic [0:4][4:0] g;
  logic [4:0]      g_row;
  logic            pixel_d;

  always_comb begin
    g       = glyph(nib_q);
    g_row   = row_q < 3'd5 ? g[row_q] : 5'd0;
    pixel_d = in_q && !blank_q && xbit_q < 3'd5 && g_row[xbit_q < 3'd5 ? 3'd4 - xbit_q : 3'd0];
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) pixel_q <= 1'b0;
    else        pixel_q <= pixel_d;

  assign score    = score_q;
  assign overflow = ovf_q;
  assign pixel    = pixel_q;
endmodule
